rob_commit: RTL
===============

// Module: rob_commit
// PURPOSE
// - Reorder buffer with in-order commit; sits directly upstream of the architectural register file.
// - Allocates one entry per cycle at dispatch in program order.
// - Accepts up to 2 out-of-order completions per cycle.
// - Retires up to 2 completed head entries per cycle, driving the register file's dual write port.
// PARAMETERS
// - AR_SIZE    6   architectural register index width; matches the register file
// - ROB_DEPTH  16  entry count; power of 2, >= 4
// - IDX_W      4   log2(ROB_DEPTH); ROB tag width
// PORTS
// - clk            in   1        clock; all state updates on rising edge
// - rst            in   1        reset, asynchronous, active-high
// - flush          in   1        discard all entries (mispredict/exception)
// - alloc_valid    in   1        dispatch requests one entry
// - alloc_rd       in   AR_SIZE  destination register; 0 = no register write
// - alloc_ready    out  1        entry available (count < ROB_DEPTH)
// - alloc_idx      out  IDX_W    tag granted to a request in this cycle (= tail)
// - cmp_valid1     in   1        completion port 1 valid
// - cmp_idx1       in   IDX_W    completion port 1 tag
// - cmp_data1      in   32       completion port 1 result
// - cmp_valid2     in   1        completion port 2 valid
// - cmp_idx2       in   IDX_W    completion port 2 tag
// - cmp_data2      in   32       completion port 2 result
// - write_addr1    out  AR_SIZE  retire slot 1 (older) destination
// - write_data1    out  32       retire slot 1 result
// - write_addr2    out  AR_SIZE  retire slot 2 (younger) destination
// - write_data2    out  32       retire slot 2 result
// - write_en       out  1        at least one entry retired
// - retire_count   out  2        entries retired (0..2)
// BEHAVIOUR
// - Reset:
//   - head, tail and count clear to 0; every entry valid/done bit clears to 0.
//   - write_en = 0; retire_count = 0; write_addr*/write_data* = 0; alloc_ready = 1; alloc_idx = 0.
// - Storage: circular array of {valid, done, rd, data}.
//   - head/tail are IDX_W bits and wrap naturally.
//   - count is IDX_W+1 bits.
// - Allocation (alloc_valid && alloc_ready):
//   - entry[tail] <= {valid=1, done=0, rd=alloc_rd}; tail <= tail+1.
//   - alloc_valid while full is ignored; no state changes.
// - Completion:
//   - If entry[cmp_idxN].valid, set done=1 and data=cmp_dataN.
//   - A completion that targets an invalid entry is ignored.
//   - If both ports carry the same tag, port 1 wins.
//   - done is registered, so a completed entry is first retire-eligible in the next cycle.
// - Retire selection (combinational, from registered state):
//   - r1 = entry[head].valid && entry[head].done.
//   - r2 = r1 && entry[head+1].valid && entry[head+1].done.
// - Retire outputs (registered, 1-cycle latency):
//   - write_en <= r1; retire_count <= r1+r2.
//   - Slot 1 carries head; slot 2 carries head+1.
//   - A non-retiring slot drives addr 0 and data 0.
//   - An entry with rd = 0 retires normally with addr 0, so the register file suppresses the write.
//   - Retired entries clear valid; head advances by retire_count.
// - Same rd in both slots: slot 2 (younger) is on write port 2, and the register file applies port 2 last, so the younger result wins.
// - Simultaneous events: count <= count + alloc_fire - (r1+r2).
//   - Allocating into an entry freed in the same cycle is legal only if count was not full.
//   - alloc_ready is derived from the registered count; retires do not bypass it.
// - Flush:
//   - Clears all valid/done bits; head = tail = count = 0.
//   - Next-cycle write_en = 0 and retire_count = 0.
//   - Overrides alloc, complete and retire in the same cycle.
// - Reset mid-operation: asynchronous return to reset values; in-flight completions are lost.
// - alloc_ready and alloc_idx are combinational from registered count/tail; no input-to-output combinational path.
// STRUCTURE
// - Package rob_pkg holds:
//   - AR_SIZE, ROB_DEPTH, IDX_W constants;
//   - rob_entry_t {valid, done, rd[AR_SIZE], data[32]}.
// - Sub-module rob_retire_sel (combinational):
//   - inputs: head plus the 2 head entries;
//   - outputs: r1, r2, slot addr/data.
// - Top level keeps pointers, count, entry array and output registers.
// TESTING
// - Reset, then alloc rd=5 and complete with data 0xDEAD0005
//   -> 1 cycle later: write_en=1, write_addr1=5, write_data1=0xDEAD0005, write_addr2=0, retire_count=1.
// - Alloc rd=1,2; complete tag1 before tag0
//   -> nothing retires until tag0 completes; then both retire in one cycle (addr1=1, addr2=2, count=2).
// - Alloc 16 -> alloc_ready=0; 17th alloc_valid ignored (tail unchanged)
//   -> after head retires, alloc_ready=1; next tag wraps to idx 0.
// - Both slots rd=7, data 0x11 (older) and 0x22 (younger)
//   -> write_addr1=write_addr2=7; register file holds 0x22.
// - Fill 6 entries, complete 3, assert flush with a simultaneous alloc
//   -> next cycle count=0, write_en=0, alloc_idx=0; a late completion to old tag 2 is ignored.
// - Assert rst mid-stream with 2 retirable entries -> outputs 0 immediately, no retire after release.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared constants and the reorder-buffer entry layout for the commit block.
package rob_pkg;

   localparam int AR_SIZE   = 6;
   localparam int ROB_DEPTH = 16;
   localparam int IDX_W     = 4;

   typedef struct packed {
      logic               valid;
      logic               done;
      logic [AR_SIZE-1:0] rd;
      logic [31:0]        data;
   } rob_entry_t;

endpackage

// File: rtl/rob_commit_if.sv
// Dispatch, completion and register-file write bundle around the ROB.
// Handshake: an entry is allocated on any rising edge where alloc_valid && alloc_ready;
// completions and retire writes are fire-and-forget qualified by their valid/write_en.
interface rob_commit_if;
   import rob_pkg::*;

   logic               flush;
   logic               alloc_valid;
   logic [AR_SIZE-1:0] alloc_rd;
   logic               alloc_ready;
   logic [IDX_W-1:0]   alloc_idx;
   logic               cmp_valid1;
   logic [IDX_W-1:0]   cmp_idx1;
   logic [31:0]        cmp_data1;
   logic               cmp_valid2;
   logic [IDX_W-1:0]   cmp_idx2;
   logic [31:0]        cmp_data2;
   logic [AR_SIZE-1:0] write_addr1;
   logic [31:0]        write_data1;
   logic [AR_SIZE-1:0] write_addr2;
   logic [31:0]        write_data2;
   logic               write_en;
   logic [1:0]         retire_count;
   logic [IDX_W:0]     dbg_count;

   modport slave (
      input  flush, alloc_valid, alloc_rd,
      input  cmp_valid1, cmp_idx1, cmp_data1,
      input  cmp_valid2, cmp_idx2, cmp_data2,
      output alloc_ready, alloc_idx,
      output write_addr1, write_data1, write_addr2, write_data2,
      output write_en, retire_count, dbg_count
   );

   modport master (
      output flush, alloc_valid, alloc_rd,
      output cmp_valid1, cmp_idx1, cmp_data1,
      output cmp_valid2, cmp_idx2, cmp_data2,
      input  alloc_ready, alloc_idx,
      input  write_addr1, write_data1, write_addr2, write_data2,
      input  write_en, retire_count, dbg_count
   );

endinterface

// File: rtl/rob_retire_sel.sv
// Picks up to two completed entries at the head for retirement this cycle.
module rob_retire_sel
   import rob_pkg::*;
(
   input  logic [IDX_W-1:0]   head_i,
   input  rob_entry_t         ent1_i,
   input  rob_entry_t         ent2_i,
   output logic [IDX_W-1:0]   idx2_o,
   output logic [IDX_W-1:0]   head_nxt_o,
   output logic               r1_o,
   output logic               r2_o,
   output logic [1:0]         cnt_o,
   output logic [AR_SIZE-1:0] addr1_o,
   output logic [31:0]        data1_o,
   output logic [AR_SIZE-1:0] addr2_o,
   output logic [31:0]        data2_o
);

   always_comb begin
      idx2_o  = head_i + IDX_W'(1);
      r1_o    = ent1_i.valid && ent1_i.done;
      r2_o    = r1_o && ent2_i.valid && ent2_i.done;
      cnt_o   = {1'b0, r1_o} + {1'b0, r2_o};
      addr1_o = '0;
      data1_o = '0;
      addr2_o = '0;
      data2_o = '0;
      // Idle slots drive zeros so the register file sees a harmless address 0.
      if (r1_o) begin
         addr1_o = ent1_i.rd;
         data1_o = ent1_i.data;
      end
      if (r2_o) begin
         addr2_o = ent2_i.rd;
         data2_o = ent2_i.data;
      end
      head_nxt_o = head_i + IDX_W'(cnt_o);
   end

endmodule

// File: rtl/rob_commit.sv
// Reorder buffer: in-order allocate, dual out-of-order completion, dual in-order retire.
module rob_commit
   import rob_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   rob_commit_if.slave   bus
);

   rob_entry_t         entries_q [ROB_DEPTH];
   rob_entry_t         entries_d [ROB_DEPTH];
   logic [IDX_W-1:0]   head_q, head_d;
   logic [IDX_W-1:0]   tail_q, tail_d;
   logic [IDX_W:0]     count_q, count_d;

   logic               write_en_q, write_en_d;
   logic [1:0]         retire_count_q, retire_count_d;
   logic [AR_SIZE-1:0] write_addr1_q, write_addr1_d;
   logic [31:0]        write_data1_q, write_data1_d;
   logic [AR_SIZE-1:0] write_addr2_q, write_addr2_d;
   logic [31:0]        write_data2_q, write_data2_d;

   logic               alloc_ready;
   logic               alloc_fire;
   logic [IDX_W-1:0]   idx2;
   logic [IDX_W-1:0]   head_nxt;
   logic               r1, r2;
   logic [1:0]         ret_cnt;
   logic [AR_SIZE-1:0] sel_addr1, sel_addr2;
   logic [31:0]        sel_data1, sel_data2;

   assign alloc_ready = (count_q != (IDX_W+1)'(ROB_DEPTH));
   assign alloc_fire  = bus.alloc_valid && alloc_ready;

   rob_retire_sel u_sel (
      .head_i     (head_q),
      .ent1_i     (entries_q[head_q]),
      .ent2_i     (entries_q[idx2]),
      .idx2_o     (idx2),
      .head_nxt_o (head_nxt),
      .r1_o       (r1),
      .r2_o       (r2),
      .cnt_o      (ret_cnt),
      .addr1_o    (sel_addr1),
      .data1_o    (sel_data1),
      .addr2_o    (sel_addr2),
      .data2_o    (sel_data2)
   );

   // Port 2 is applied before port 1 so a same-tag collision resolves to port 1.
   always_comb begin
      entries_d = entries_q;
      if (bus.cmp_valid2 && entries_q[bus.cmp_idx2].valid) begin
         entries_d[bus.cmp_idx2].done = 1'b1;
         entries_d[bus.cmp_idx2].data = bus.cmp_data2;
      end
      if (bus.cmp_valid1 && entries_q[bus.cmp_idx1].valid) begin
         entries_d[bus.cmp_idx1].done = 1'b1;
         entries_d[bus.cmp_idx1].data = bus.cmp_data1;
      end
      if (r1) begin
         entries_d[head_q].valid = 1'b0;
         entries_d[head_q].done  = 1'b0;
      end
      if (r2) begin
         entries_d[idx2].valid = 1'b0;
         entries_d[idx2].done  = 1'b0;
      end
      if (alloc_fire) begin
         entries_d[tail_q].valid = 1'b1;
         entries_d[tail_q].done  = 1'b0;
         entries_d[tail_q].rd    = bus.alloc_rd;
         entries_d[tail_q].data  = '0;
      end
      if (bus.flush) begin
         for (int i = 0; i < ROB_DEPTH; i++) begin
            entries_d[i].valid = 1'b0;
            entries_d[i].done  = 1'b0;
         end
      end
   end

   always_comb begin
      head_d         = head_nxt;
      tail_d         = tail_q + IDX_W'(alloc_fire);
      count_d        = count_q + (IDX_W+1)'(alloc_fire) - (IDX_W+1)'(ret_cnt);
      write_en_d     = r1;
      retire_count_d = ret_cnt;
      write_addr1_d  = sel_addr1;
      write_data1_d  = sel_data1;
      write_addr2_d  = sel_addr2;
      write_data2_d  = sel_data2;
      if (bus.flush) begin
         head_d         = '0;
         tail_d         = '0;
         count_d        = '0;
         write_en_d     = 1'b0;
         retire_count_d = '0;
         write_addr1_d  = '0;
         write_data1_d  = '0;
         write_addr2_d  = '0;
         write_data2_d  = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ROB_DEPTH; i++) begin
            entries_q[i] <= '0;
         end
         head_q         <= '0;
         tail_q         <= '0;
         count_q        <= '0;
         write_en_q     <= 1'b0;
         retire_count_q <= '0;
         write_addr1_q  <= '0;
         write_data1_q  <= '0;
         write_addr2_q  <= '0;
         write_data2_q  <= '0;
      end else begin
         entries_q      <= entries_d;
         head_q         <= head_d;
         tail_q         <= tail_d;
         count_q        <= count_d;
         write_en_q     <= write_en_d;
         retire_count_q <= retire_count_d;
         write_addr1_q  <= write_addr1_d;
         write_data1_q  <= write_data1_d;
         write_addr2_q  <= write_addr2_d;
         write_data2_q  <= write_data2_d;
      end
   end

   assign bus.alloc_ready  = alloc_ready;
   assign bus.alloc_idx    = tail_q;
   assign bus.write_en     = write_en_q;
   assign bus.retire_count = retire_count_q;
   assign bus.write_addr1  = write_addr1_q;
   assign bus.write_data1  = write_data1_q;
   assign bus.write_addr2  = write_addr2_q;
   assign bus.write_data2  = write_data2_q;
   assign bus.dbg_count    = count_q;

endmodule
